// File: rtl/riscv_pkg.sv
// Shared definitions for the instruction fetch slice.
//   fetch_state_e    : fetch FSM states (BOOT, FETCH, HOLD, ERR)
//   NOP_INSTR        : addi x0,x0,0, loaded into the instruction register on reset/error
//   RESET_PC_DEFAULT : default first fetch address after reset
package riscv_pkg;

    typedef enum logic [1:0] {
        BOOT  = 2'd0,
        FETCH = 2'd1,
        HOLD  = 2'd2,
        ERR   = 2'd3
    } fetch_state_e;

    localparam logic [31:0] NOP_INSTR        = 32'h0000_0013;
    localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;

endpackage

// File: rtl/pc_reg.sv
// Fetch program counter with its next-PC mux and +4 adder.
//   clk, reset : clock, asynchronous active-low reset
//   load       : commit next_pc into the PC (aligned consume only)
//   pc_src     : select pc_target instead of pc_q+4
//   pc_target  : redirect address
//   pc_q       : current fetch PC
//   pc_plus4   : pc_q + 4 (wraps modulo 2^32)
//   next_pc    : candidate next PC, examined for alignment by the FSM
module pc_reg
    import riscv_pkg::*;
#(
    parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        load,
    input  logic        pc_src,
    input  logic [31:0] pc_target,
    output logic [31:0] pc_q,
    output logic [31:0] pc_plus4,
    output logic [31:0] next_pc
);

    assign pc_plus4 = pc_q + 32'd4;
    assign next_pc  = pc_src ? pc_target : pc_plus4;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pc_q <= RESET_PC;
        end else if (load) begin
            pc_q <= next_pc;
        end
    end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch unit: issues one word fetch, holds the returned instruction
// until the decode stage consumes it, then steps or redirects the PC.
//   clk, reset              : clock, asynchronous active-low reset
//   imem_req, imem_addr     : fetch request and word address (FETCH state only)
//   imem_rvalid, imem_rdata : response strobe and data, honoured only in FETCH
//   stall                   : decode cannot consume the held instruction
//   PCSrc, PCTarget         : redirect for the consumed instruction
//   instruction, PC, PCPlus4: registered fetched instruction and its address
//   instr_valid             : the three registers above hold a valid fetch
//   fetch_err               : sticky misaligned next-PC flag
//   dbg_state               : current FSM state, for observation only
//
// Handshake: the request is a req/ack pair -- imem_req and imem_addr stay
// constant from entering FETCH until the cycle imem_rvalid is sampled high;
// that edge transfers the word. Toward decode, instr_valid acts as valid and
// !stall as ready: the instruction transfers on an edge where both are high,
// and nothing on the output side moves while stall is high.
module fetch_unit
    import riscv_pkg::*;
#(
    parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
) (
    input  logic         clk,
    input  logic         reset,
    output logic         imem_req,
    output logic [31:0]  imem_addr,
    input  logic         imem_rvalid,
    input  logic [31:0]  imem_rdata,
    input  logic         stall,
    input  logic         PCSrc,
    input  logic [31:0]  PCTarget,
    output logic [31:0]  instruction,
    output logic [31:0]  PC,
    output logic [31:0]  PCPlus4,
    output logic         instr_valid,
    output logic         fetch_err,
    output fetch_state_e dbg_state
);

    fetch_state_e state, state_n;
    logic [31:0]  pc_q, pc_plus4, next_pc;
    logic         capture, consume, misaligned;

    assign misaligned = (next_pc[1:0] != 2'b00);

    // PCSrc/PCTarget reach the PC only through load, so they have no effect
    // outside an aligned consume cycle.
    pc_reg #(.RESET_PC(RESET_PC)) u_pc_reg (
        .clk       (clk),
        .reset     (reset),
        .load      (consume && !misaligned),
        .pc_src    (PCSrc),
        .pc_target (PCTarget),
        .pc_q      (pc_q),
        .pc_plus4  (pc_plus4),
        .next_pc   (next_pc)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= BOOT;
        end else begin
            state <= state_n;
        end
    end

    // imem_req decodes straight from the state register so an asynchronous
    // reset removes it in the same instant.
    always_comb begin
        state_n  = state;
        imem_req = 1'b0;
        capture  = 1'b0;
        consume  = 1'b0;
        case (state)
            BOOT: state_n = FETCH;
            FETCH: begin
                imem_req = 1'b1;
                if (imem_rvalid) begin
                    capture = 1'b1;
                    state_n = HOLD;
                end
            end
            HOLD: begin
                if (!stall) begin
                    consume = 1'b1;
                    state_n = misaligned ? ERR : FETCH;
                end
            end
            ERR:     state_n = ERR;
            default: state_n = BOOT;
        endcase
    end

    assign imem_addr = pc_q;
    assign dbg_state = state;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            instruction <= NOP_INSTR;
            PC          <= RESET_PC;
            PCPlus4     <= RESET_PC + 32'd4;
            instr_valid <= 1'b0;
            fetch_err   <= 1'b0;
        end else begin
            if (capture) begin
                instruction <= imem_rdata;
                PC          <= pc_q;
                PCPlus4     <= pc_plus4;
                instr_valid <= 1'b1;
            end
            if (consume) begin
                instr_valid <= 1'b0;
                if (misaligned) begin
                    fetch_err   <= 1'b1;
                    instruction <= NOP_INSTR;
                end
            end
        end
    end

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit. Two instances share every input: dut (RESET_PC=0) and
// dut_w (RESET_PC=FFFF_FFFC) which runs in lockstep and shows PC wrap-around.
module tb_fetch_unit;
    import riscv_pkg::*;

    localparam logic [31:0] WRAP_PC = 32'hFFFF_FFFC;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    logic         imem_rvalid, stall, PCSrc;
    logic [31:0]  imem_rdata, PCTarget;
    logic         imem_req, instr_valid, fetch_err;
    logic [31:0]  imem_addr, instruction, PC, PCPlus4;
    fetch_state_e dbg_state;
    logic         w_imem_req, w_instr_valid, w_fetch_err;
    logic [31:0]  w_imem_addr, w_instruction, w_PC, w_PCPlus4;
    fetch_state_e w_dbg_state;

    fetch_unit #(.RESET_PC(32'h0000_0000)) dut (
        .clk(clk), .reset(reset), .imem_req(imem_req), .imem_addr(imem_addr),
        .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata), .stall(stall),
        .PCSrc(PCSrc), .PCTarget(PCTarget), .instruction(instruction), .PC(PC),
        .PCPlus4(PCPlus4), .instr_valid(instr_valid), .fetch_err(fetch_err),
        .dbg_state(dbg_state)
    );

    fetch_unit #(.RESET_PC(WRAP_PC)) dut_w (
        .clk(clk), .reset(reset), .imem_req(w_imem_req), .imem_addr(w_imem_addr),
        .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata), .stall(stall),
        .PCSrc(PCSrc), .PCTarget(PCTarget), .instruction(w_instruction), .PC(w_PC),
        .PCPlus4(w_PCPlus4), .instr_valid(w_instr_valid), .fetch_err(w_fetch_err),
        .dbg_state(w_dbg_state)
    );

    // ---------------- scoreboard / reference model ----------------
    int checks = 0;
    int errors = 0;
    logic [31:0] model_pc;      // address the next fetch must use / PC of held word
    logic [31:0] model_instr;   // word the instruction register must hold
    logic [31:0] exp_q[$];      // words returned by memory, in fetch order

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        imem_rvalid = 1'b0;
        imem_rdata  = 32'h0;
        stall       = 1'b0;
        PCSrc       = 1'b0;
        PCTarget    = 32'h0;
    endtask

    // Fetch one word from the current FETCH state after lat wait cycles.
    task automatic fetch_one(input int lat);
        logic [31:0] d;
        for (int k = 0; k < lat; k++) begin
            imem_rvalid = 1'b0;
            imem_rdata  = $urandom;
            checks++;
            if ({imem_req, imem_addr, instr_valid, instruction} !== {1'b1, model_pc, 1'b0, model_instr}) begin
                errors++;
                $display("FAIL fetch_wait: req=%0b addr=%h valid=%0b instr=%h, want req=1 addr=%h valid=0 instr=%h",
                         imem_req, imem_addr, instr_valid, instruction, model_pc, model_instr);
            end
            tick();
        end
        d           = $urandom;
        imem_rvalid = 1'b1;
        imem_rdata  = d;
        exp_q.push_back(d);
        checks++;
        if ({imem_req, imem_addr} !== {1'b1, model_pc}) begin
            errors++;
            $display("FAIL fetch_req: req=%0b addr=%h, want req=1 addr=%h", imem_req, imem_addr, model_pc);
        end
        tick();
        imem_rvalid = 1'b0;
        model_instr = exp_q.pop_front();
        checks++;
        if ({instr_valid, instruction, PC, PCPlus4, imem_req} !== {1'b1, model_instr, model_pc, model_pc + 32'd4, 1'b0}) begin
            errors++;
            $display("FAIL capture: valid=%0b instr=%h PC=%h PCPlus4=%h req=%0b, want 1 %h %h %h 0",
                     instr_valid, instruction, PC, PCPlus4, imem_req, model_instr, model_pc, model_pc + 32'd4);
        end
    endtask

    // Hold the instruction for `stalls` cycles (with noisy redirect/response
    // inputs that must be ignored), then consume with the given redirect.
    task automatic consume(input int stalls, input bit src, input logic [31:0] tgt);
        logic [31:0] nxt;
        for (int k = 0; k < stalls; k++) begin
            stall       = 1'b1;
            PCSrc       = 1'b1;
            PCTarget    = $urandom;
            imem_rvalid = 1'($urandom_range(0, 1));
            imem_rdata  = $urandom;
            tick();
            checks++;
            if ({instr_valid, instruction, PC, PCPlus4, imem_req, fetch_err} !==
                {1'b1, model_instr, model_pc, model_pc + 32'd4, 1'b0, 1'b0}) begin
                errors++;
                $display("FAIL stall_hold: valid=%0b instr=%h PC=%h PCPlus4=%h req=%0b err=%0b, want 1 %h %h %h 0 0",
                         instr_valid, instruction, PC, PCPlus4, imem_req, fetch_err,
                         model_instr, model_pc, model_pc + 32'd4);
            end
        end
        stall       = 1'b0;
        PCSrc       = src;
        PCTarget    = tgt;
        imem_rvalid = 1'($urandom_range(0, 1));
        imem_rdata  = $urandom;
        tick();
        idle_inputs();
        nxt = src ? tgt : model_pc + 32'd4;
        checks++;
        if (nxt[1:0] == 2'b00) begin
            if ({instr_valid, imem_req, imem_addr, fetch_err} !== {1'b0, 1'b1, nxt, 1'b0}) begin
                errors++;
                $display("FAIL consume: valid=%0b req=%0b addr=%h err=%0b, want 0 1 %h 0",
                         instr_valid, imem_req, imem_addr, fetch_err, nxt);
            end
            model_pc = nxt;
        end else begin
            model_instr = NOP_INSTR;
            if ({instr_valid, imem_req, fetch_err, instruction, dbg_state} !== {1'b0, 1'b0, 1'b1, NOP_INSTR, ERR}) begin
                errors++;
                $display("FAIL consume_err: valid=%0b req=%0b err=%0b instr=%h state=%0d, want 0 0 1 %h %0d",
                         instr_valid, imem_req, fetch_err, instruction, dbg_state, NOP_INSTR, ERR);
            end
        end
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        idle_inputs();
        reset = 1'b0;
        tick();
        tick();
        checks++;
        if ({imem_req, instr_valid, fetch_err, instruction, PC, PCPlus4, dbg_state} !==
            {1'b0, 1'b0, 1'b0, NOP_INSTR, 32'h0, 32'h4, BOOT}) begin
            errors++;
            $display("FAIL reset_state: req=%0b valid=%0b err=%0b instr=%h PC=%h PCPlus4=%h state=%0d",
                     imem_req, instr_valid, fetch_err, instruction, PC, PCPlus4, dbg_state);
        end
        checks++;
        if ({w_PC, w_PCPlus4, w_imem_req} !== {WRAP_PC, 32'h0, 1'b0}) begin
            errors++;
            $display("FAIL reset_wrap: PC=%h PCPlus4=%h req=%0b, want %h 00000000 0", w_PC, w_PCPlus4, w_imem_req, WRAP_PC);
        end
        reset       = 1'b1;
        model_pc    = 32'h0;
        model_instr = NOP_INSTR;
        checks++;
        if ({imem_req, dbg_state} !== {1'b0, BOOT}) begin
            errors++;
            $display("FAIL boot_cycle: req=%0b state=%0d, want 0 %0d", imem_req, dbg_state, BOOT);
        end
        tick();
        checks++;
        if ({imem_req, imem_addr, dbg_state} !== {1'b1, 32'h0, FETCH}) begin
            errors++;
            $display("FAIL first_fetch: req=%0b addr=%h state=%0d, want 1 00000000 %0d", imem_req, imem_addr, dbg_state, FETCH);
        end
    endtask

    task automatic test_sequential();
        for (int i = 0; i < 3; i++) begin
            fetch_one(0);
            if (i == 0) begin
                checks++;
                if ({w_PC, w_PCPlus4, w_instr_valid, w_instruction} !== {WRAP_PC, 32'h0, 1'b1, model_instr}) begin
                    errors++;
                    $display("FAIL wrap_capture: PC=%h PCPlus4=%h valid=%0b instr=%h, want %h 00000000 1 %h",
                             w_PC, w_PCPlus4, w_instr_valid, w_instruction, WRAP_PC, model_instr);
                end
            end
            consume(0, 1'b0, 32'h0);
            if (i == 0) begin
                checks++;
                if ({w_imem_req, w_imem_addr} !== {1'b1, 32'h0}) begin
                    errors++;
                    $display("FAIL wrap_fetch: req=%0b addr=%h, want 1 00000000", w_imem_req, w_imem_addr);
                end
            end
        end
        checks++;
        if (imem_addr !== 32'h0000_000C) begin
            errors++;
            $display("FAIL seq_addr: addr=%h, want 0000000c", imem_addr);
        end
    endtask

    task automatic test_wait();
        fetch_one(5);
        consume(0, 1'b0, 32'h0);
    endtask

    task automatic test_stall_redirect();
        fetch_one(1);
        checks++;
        if (PC !== 32'h0000_0010) begin
            errors++;
            $display("FAIL stall_pc: PC=%h, want 00000010", PC);
        end
        consume(3, 1'b1, 32'h0000_0040);
        checks++;
        if (imem_addr !== 32'h0000_0040) begin
            errors++;
            $display("FAIL redirect_addr: addr=%h, want 00000040", imem_addr);
        end
    endtask

    task automatic test_random();
        logic [31:0] t;
        for (int i = 0; i < 40; i++) begin
            t = $urandom;
            t[1:0] = 2'b00;
            fetch_one($urandom_range(0, 3));
            consume($urandom_range(0, 2), 1'($urandom_range(0, 1)), t);
        end
    endtask

    task automatic test_reset_mid_fetch();
        imem_rvalid = 1'b0;
        #2;
        reset = 1'b0;
        #1;
        checks++;
        if ({imem_req, dbg_state} !== {1'b0, BOOT}) begin
            errors++;
            $display("FAIL async_drop: req=%0b state=%0d, want 0 %0d", imem_req, dbg_state, BOOT);
        end
        tick();
        reset       = 1'b1;
        model_pc    = 32'h0;
        model_instr = NOP_INSTR;
        // stale response lands in the boot cycle after release
        imem_rvalid = 1'b1;
        imem_rdata  = 32'hDEAD_BEEF;
        tick();
        imem_rvalid = 1'b0;
        checks++;
        if ({imem_req, imem_addr, instr_valid, instruction} !== {1'b1, 32'h0, 1'b0, NOP_INSTR}) begin
            errors++;
            $display("FAIL stale_resp: req=%0b addr=%h valid=%0b instr=%h, want 1 00000000 0 %h",
                     imem_req, imem_addr, instr_valid, instruction, NOP_INSTR);
        end
        fetch_one(0);
        consume(0, 1'b0, 32'h0);
    endtask

    task automatic test_error();
        fetch_one(0);
        consume(1, 1'b1, 32'h0000_0042);
        for (int k = 0; k < 4; k++) begin
            imem_rvalid = 1'b1;
            imem_rdata  = $urandom;
            stall       = 1'($urandom_range(0, 1));
            PCSrc       = 1'($urandom_range(0, 1));
            PCTarget    = 32'h0000_0100;
            tick();
            checks++;
            if ({imem_req, instr_valid, fetch_err, instruction, dbg_state} !== {1'b0, 1'b0, 1'b1, NOP_INSTR, ERR}) begin
                errors++;
                $display("FAIL err_sticky: req=%0b valid=%0b err=%0b instr=%h state=%0d",
                         imem_req, instr_valid, fetch_err, instruction, dbg_state);
            end
        end
        checks++;
        if ({w_fetch_err, w_dbg_state} !== {1'b1, ERR}) begin
            errors++;
            $display("FAIL err_wrap: err=%0b state=%0d, want 1 %0d", w_fetch_err, w_dbg_state, ERR);
        end
        idle_inputs();
        reset = 1'b0;
        tick();
        checks++;
        if ({fetch_err, dbg_state, imem_req} !== {1'b0, BOOT, 1'b0}) begin
            errors++;
            $display("FAIL err_cleared: err=%0b state=%0d req=%0b", fetch_err, dbg_state, imem_req);
        end
        reset = 1'b1;
    endtask

    // ---------------- sequence and report ----------------
    initial begin
        test_reset();
        test_sequential();
        test_wait();
        test_stall_redirect();
        test_random();
        test_reset_mid_fetch();
        test_error();
        tick();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: bench did not finish, errors=%0d checks=%0d", errors, checks);
        $fatal(1);
    end

endmodule
